pipeline_hazard_ctrl: RTL

Central stall/flush/forwarding controller for the 5-stage 64-bit pipeline (IF, ID, EX, MEM, WB).
- Drives enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Detects load-use hazards and selects EX-stage operand forwarding.
- Freezes the whole pipeline while a data-memory access waits for acknowledge.
- Enters a locked error state on memory timeout.

---
 rtl/pipeline_hazard_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, with memory-wait freeze and timeout lock.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic [4:0]  ex_rs1_i,
   input  logic [4:0]  ex_rs2_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        ex_memread_i,
   input  logic        branch_taken_i,
   input  logic [4:0]  mem_rd_i,
   input  logic        mem_regwrite_i,
   input  logic [4:0]  wb_rd_i,
   input  logic        wb_regwrite_i,
   input  logic        dmem_req_i,
   input  logic        dmem_ack_i,
   output logic        pc_en_o,
   output logic        ifid_en_o,
   output logic        ifid_flush_o,
   output logic        idex_en_o,
   output logic        idex_flush_o,
   output logic        exmem_en_o,
   output logic        memwb_flush_o,
   output logic [1:0]  fwd_a_o,
   output logic [1:0]  fwd_b_o,
   output logic        err_o
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] perf_lu_o,
   output logic [31:0] perf_flush_o,
   output logic [31:0] perf_wait_o
`endif
);

   localparam int unsigned CNT_INC_W = CNT_W + 1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;

   logic [CNT_INC_W-1:0] cnt_inc;
   logic                 timeout_hit;
   logic                 lu;
   logic                 freeze;
   logic                 br_flush;
   logic                 lu_bubble;

   // EX/MEM result wins over MEM/WB; x0 is never forwarded
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       mrw, input logic [4:0] mrd,
                                          input logic       wrw, input logic [4:0] wrd);
      logic [1:0] sel;
      sel = 2'b00;
      if (mrw && (mrd != 5'd0) && (mrd == rs)) begin
         sel = 2'b10;
      end else if (wrw && (wrd != 5'd0) && (wrd == rs)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   assign cnt_inc     = {1'b0, cnt_q} + CNT_INC_W'(1);
   assign timeout_hit = (cnt_inc >= CNT_INC_W'(MEM_TIMEOUT));
   assign lu          = ex_memread_i && (ex_rd_i != 5'd0) &&
                        ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

   // next-state and combinational pipeline controls
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
      freeze        = 1'b0;
      pc_en_o       = 1'b1;
      ifid_en_o     = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_en_o     = 1'b1;
      idex_flush_o  = 1'b0;
      exmem_en_o    = 1'b1;
      memwb_flush_o = 1'b0;
      fwd_a_o       = fwd_sel(ex_rs1_i, mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i);
      fwd_b_o       = fwd_sel(ex_rs2_i, mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i);

      unique case (state_q)
         ST_RUN: begin
            freeze = dmem_req_i && !dmem_ack_i;
            if (freeze) begin
               state_d = ST_MEM_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            freeze = !dmem_ack_i;
            if (dmem_ack_i) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc[CNT_W-1:0];
               if (timeout_hit) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         ST_ERR: begin
            freeze = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase

      br_flush  = !freeze && branch_taken_i;
      lu_bubble = !freeze && !branch_taken_i && lu;

      if (freeze) begin
         pc_en_o       = 1'b0;
         ifid_en_o     = 1'b0;
         idex_en_o     = 1'b0;
         exmem_en_o    = 1'b0;
         memwb_flush_o = 1'b1;
      end else if (br_flush) begin
         ifid_flush_o = 1'b1;
         idex_flush_o = 1'b1;
      end else if (lu_bubble) begin
         pc_en_o      = 1'b0;
         ifid_en_o    = 1'b0;
         idex_flush_o = 1'b1;
      end

      // reset forces a quiet, free-running pipeline regardless of inputs
      if (!rst_ni) begin
         pc_en_o       = 1'b1;
         ifid_en_o     = 1'b1;
         ifid_flush_o  = 1'b0;
         idex_en_o     = 1'b1;
         idex_flush_o  = 1'b0;
         exmem_en_o    = 1'b1;
         memwb_flush_o = 1'b0;
         fwd_a_o       = 2'b00;
         fwd_b_o       = 2'b00;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign err_o = err_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_lu_q, perf_flush_q, perf_wait_q;

   // event counters, wrapping naturally at 2^32
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_lu_q    <= '0;
         perf_flush_q <= '0;
         perf_wait_q  <= '0;
      end else begin
         if (lu_bubble) perf_lu_q <= perf_lu_q + 32'd1;
         if (br_flush) perf_flush_q <= perf_flush_q + 32'd1;
         if (freeze && (state_q != ST_ERR)) perf_wait_q <= perf_wait_q + 32'd1;
      end
   end

   assign perf_lu_o    = perf_lu_q;
   assign perf_flush_o = perf_flush_q;
   assign perf_wait_o  = perf_wait_q;
`endif

endmodule
